// File: rtl/seg_scan_monitor.sv
// ---------------------------------------------------------------------------
// seg_scan_monitor
//
// Passive receiver for a multiplexed 4-digit seven-segment bus. The scanned
// anode/cathode lines are synchronized. Each digit slot is sampled once it
// has been stable for SETTLE_CYCLES. The cathode pattern is decoded back to
// BCD, and the four digits are assembled into complete frames. Malformed
// scans are flagged: undecodable patterns, or more than one anode active.
// A stall flag shows that no valid digit has been seen for TIMEOUT_CYCLES.
//
// Optional feature: define SEG_SCAN_MONITOR_HEX_EN to decode the hex glyphs
// A,b,C,d,E,F as 4'hA..4'hF. Without the define, these glyphs are errors.
//
// Ports
//   clk          in   system clock
//   RESET_N      in   asynchronous active-low reset
//   anode[3:0]   in   active-low digit enables, anode[0] = rightmost digit
//   cathode[6:0] in   active-low segments {g,f,e,d,c,b,a}
//   clear_err    in   synchronous clear of the sticky error flags
//   frame[15:0]  out  last complete frame, digit i in frame[4i+3:4i]
//   blank[3:0]   out  per digit: slot was all segments off in last frame
//   frame_done   out  one-cycle pulse when frame/blank update
//   err_pattern  out  sticky: undecodable cathode pattern sampled
//   err_anode    out  sticky: more than one anode low when sampled
//   stall        out  no valid sample for TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module seg_scan_monitor #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        clear_err,
  output logic [15:0] frame,
  output logic [3:0]  blank,
  output logic        frame_done,
  output logic        err_pattern,
  output logic        err_anode,
  output logic        stall
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] value;
  } decode_t;

  // Cathode pattern to digit value. Lit segments are 0.
  function automatic decode_t decode_seg(input logic [6:0] seg);
    decode_t d;
    d = '{err: 1'b0, blank: 1'b0, value: 4'h0};
    case (seg)
      7'b1000000: d.value = 4'h0;
      7'b1111001: d.value = 4'h1;
      7'b0100100: d.value = 4'h2;
      7'b0110000: d.value = 4'h3;
      7'b0011001: d.value = 4'h4;
      7'b0010010: d.value = 4'h5;
      7'b0000010: d.value = 4'h6;
      7'b1111000: d.value = 4'h7;
      7'b0000000: d.value = 4'h8;
      7'b0010000: d.value = 4'h9;
      7'b1111111: d.blank = 1'b1;
`ifdef SEG_SCAN_MONITOR_HEX_EN
      7'b0001000: d.value = 4'hA;
      7'b0000011: d.value = 4'hB;
      7'b1000110: d.value = 4'hC;
      7'b0100001: d.value = 4'hD;
      7'b0000110: d.value = 4'hE;
      7'b0001110: d.value = 4'hF;
`endif
      default:    d.err   = 1'b1;
    endcase
    return d;
  endfunction

  // -------------------------------------------------------------------------
  // Input synchronizers. They idle at all ones, which means no digit enabled
  // and all segments off.
  // -------------------------------------------------------------------------
  logic [10:0] sync1_q, sync2_q, prev_q;

  // NOTE: Sequential state uses only non-blocking assignments. Every register
  //       then updates from its pre-edge values, whatever the order of the
  //       process blocks.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= {anode, cathode};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  logic [3:0] anode_s;
  logic [6:0] cath_s;
  assign anode_s = sync2_q[10:7];
  assign cath_s  = sync2_q[6:0];

  // -------------------------------------------------------------------------
  // Settle counter. The sample event fires only on the cycle the counter
  // steps from SETTLE-1 to SETTLE. Saturation then keeps it quiet for the
  // rest of the stable period.
  // -------------------------------------------------------------------------
  logic [SW-1:0] settle_q, settle_d;
  logic          changed, sample_evt;

  assign changed    = (sync2_q != prev_q);
  assign sample_evt = !changed && (settle_q == SETTLE_LAST);

  always_comb begin
    // NOTE: Every combinational output gets a default first. Without it, a
    //       path that does not assign the output would infer a latch.
    settle_d = settle_q;
    if (changed)                      settle_d = '0;
    else if (settle_q != SETTLE_MAX)  settle_d = settle_q + SW'(1);
  end

  // -------------------------------------------------------------------------
  // Classify the sample event.
  // -------------------------------------------------------------------------
  logic       one_low, multi_low;
  logic [1:0] slot;
  decode_t    dec;

  always_comb begin
    one_low = 1'b1;
    slot    = 2'd0;
    case (anode_s)
      4'b1110: slot = 2'd0;
      4'b1101: slot = 2'd1;
      4'b1011: slot = 2'd2;
      4'b0111: slot = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign multi_low = !one_low && (anode_s != 4'b1111);
  assign dec       = decode_seg(cath_s);

  logic valid_evt, pattern_evt, anode_evt;
  assign valid_evt   = sample_evt && one_low;
  assign pattern_evt = valid_evt && dec.err;
  assign anode_evt   = sample_evt && multi_low;

  // -------------------------------------------------------------------------
  // Working digits and frame assembly. Once seen is full, the next cycle
  // publishes the frame and restarts seen.
  // -------------------------------------------------------------------------
  logic [3:0][3:0] work_q;
  logic [3:0]      wblank_q, seen_q, seen_d;
  logic [15:0]     frame_q;
  logic [3:0]      blank_q;
  logic            frame_done_q, publish;

  assign publish = (seen_q == 4'b1111);

  always_comb begin
    seen_d = publish ? 4'b0000 : seen_q;
    if (valid_evt) seen_d[slot] = 1'b1;
  end

  // NOTE: The working-digit storage is reset along with the control state.
  //       It is small, and a reset keeps X out of a partially scanned frame.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      work_q       <= '0;
      wblank_q     <= '0;
      seen_q       <= '0;
      frame_q      <= '0;
      blank_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      frame_done_q <= publish;
      if (publish) begin
        frame_q <= work_q;
        blank_q <= wblank_q;
      end
      if (valid_evt) begin
        work_q[slot]   <= dec.value;
        wblank_q[slot] <= dec.blank;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Timeout and sticky errors. If clear_err arrives with a new error, the
  // error is kept.
  // -------------------------------------------------------------------------
  logic [TW-1:0] to_q, to_d;
  logic          stall_q, err_pattern_q, err_anode_q;

  always_comb begin
    to_d = to_q;
    if (valid_evt)               to_d = '0;
    else if (to_q != TIMEOUT_MAX) to_d = to_q + TW'(1);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      settle_q      <= '0;
      to_q          <= '0;
      stall_q       <= 1'b0;
      err_pattern_q <= 1'b0;
      err_anode_q   <= 1'b0;
    end else begin
      settle_q <= settle_d;
      to_q     <= to_d;
      stall_q  <= (to_d == TIMEOUT_MAX);
      if (pattern_evt)    err_pattern_q <= 1'b1;
      else if (clear_err) err_pattern_q <= 1'b0;
      if (anode_evt)      err_anode_q   <= 1'b1;
      else if (clear_err) err_anode_q   <= 1'b0;
    end
  end

  assign frame       = frame_q;
  assign blank       = blank_q;
  assign frame_done  = frame_done_q;
  assign err_pattern = err_pattern_q;
  assign err_anode   = err_anode_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_seg_scan_monitor.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_monitor
//
// Directed bench for seg_scan_monitor, with TIMEOUT_CYCLES overridden to 64.
// A table of whole-frame scans is applied in a loop. Hand-written sequences
// then cover the sticky errors, clear/error collision, glitches, stall, and
// reset in the middle of a frame.
// ---------------------------------------------------------------------------
module tb_seg_scan_monitor;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 64;
  localparam int HOLD    = 40;

  localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100,
                         P3 = 7'b0110000, P4 = 7'b0011001, P5 = 7'b0010010,
                         P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000,
                         P9 = 7'b0010000, PBL = 7'b1111111, PBAD = 7'b1010101;
  localparam logic [6:0] HC = 7'b1000110, HD = 7'b0100001,
                         HE = 7'b0000110, HF = 7'b0001110;

  logic        clk = 1'b0;
  logic        RESET_N;
  logic [3:0]  anode;
  logic [6:0]  cathode;
  logic        clear_err;
  logic [15:0] frame;
  logic [3:0]  blank;
  logic        frame_done, err_pattern, err_anode, stall;

  seg_scan_monitor #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .anode       (anode),
    .cathode     (cathode),
    .clear_err   (clear_err),
    .frame       (frame),
    .blank       (blank),
    .frame_done  (frame_done),
    .err_pattern (err_pattern),
    .err_anode   (err_anode),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;

  typedef struct packed {
    logic [3:0][6:0] cath;     // cath[i] drives slot i
    logic [15:0]     exp_frame;
    logic [3:0]      exp_blank;
    logic            exp_errp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Step one clock. Signals are driven and sampled 1 time unit after the
  // rising edge. frame_done pulses are counted as they are seen.
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (frame_done) fd_cnt++;
    end
  endtask

  // Scan the slots whose mask bit is set, then hold the bus idle so that a
  // pending frame_done has time to appear.
  task automatic scan(input logic [3:0][6:0] cath, input logic [3:0] mask);
    fd_cnt = 0;
    for (int s = 0; s < 4; s++) begin
      if (mask[s]) begin
        anode      = 4'b1111;
        anode[s]   = 1'b0;
        cathode    = cath[s];
        steps(HOLD);
      end
    end
    anode   = 4'b1111;
    cathode = PBL;
    steps(HOLD);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    steps(3);
    RESET_N = 1'b1;
    steps(1);
  endtask

  initial begin
    anode     = 4'b1111;
    cathode   = PBL;
    clear_err = 1'b0;
    RESET_N   = 1'b0;

    vecs[0] = '{cath: {P3, P2, P1, P0},  exp_frame: 16'h3210, exp_blank: 4'b0000, exp_errp: 1'b0};
    vecs[1] = '{cath: {PBL, P2, P1, P0}, exp_frame: 16'h0210, exp_blank: 4'b1000, exp_errp: 1'b0};
    vecs[2] = '{cath: {P8, P7, P6, P5},  exp_frame: 16'h8765, exp_blank: 4'b0000, exp_errp: 1'b0};
    vecs[3] = '{cath: {P1, P4, P9, PBL}, exp_frame: 16'h1490, exp_blank: 4'b0001, exp_errp: 1'b0};
`ifdef SEG_SCAN_MONITOR_HEX_EN
    vecs[4] = '{cath: {HF, HE, HD, HC},  exp_frame: 16'hFEDC, exp_blank: 4'b0000, exp_errp: 1'b0};
`else
    vecs[4] = '{cath: {HF, HE, HD, HC},  exp_frame: 16'h0000, exp_blank: 4'b0000, exp_errp: 1'b1};
`endif

    // Reset state.
    do_reset();
    check("rst_frame", 32'(frame), 32'h0);
    check("rst_blank", 32'(blank), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_err_pattern", 32'(err_pattern), 32'h0);
    check("rst_err_anode", 32'(err_anode), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);

    // Whole-frame scans.
    for (int i = 0; i < 5; i++) begin
      scan(vecs[i].cath, 4'b1111);
      check($sformatf("vec%0d_frame", i), 32'(frame), 32'(vecs[i].exp_frame));
      check($sformatf("vec%0d_blank", i), 32'(blank), 32'(vecs[i].exp_blank));
      check($sformatf("vec%0d_frame_done_count", i), fd_cnt, 1);
      check($sformatf("vec%0d_err_pattern", i), 32'(err_pattern), 32'(vecs[i].exp_errp));
      check($sformatf("vec%0d_err_anode", i), 32'(err_anode), 32'h0);
    end
    clear_err = 1'b1;
    steps(1);
    clear_err = 1'b0;
    check("clear_after_table", 32'(err_pattern), 32'h0);

    // Bad pattern on slot 1. The error is sticky across good frames.
    scan({P3, P2, PBAD, P0}, 4'b1111);
    check("bad_frame", 32'(frame), 32'h3200);
    check("bad_err_pattern", 32'(err_pattern), 32'h1);
    scan({P3, P2, P1, P0}, 4'b1111);
    check("sticky_frame", 32'(frame), 32'h3210);
    check("sticky_err_pattern", 32'(err_pattern), 32'h1);
    clear_err = 1'b1;
    steps(1);
    clear_err = 1'b0;
    check("clear_err_pattern", 32'(err_pattern), 32'h0);

    // clear_err on the same edge as a bad sample. The sample lands on the
    // 19th edge after the drive: 2 sync, 1 change detect, 16 settle.
    anode   = 4'b1101;
    cathode = PBAD;
    steps(18);
    check("collide_before_sample", 32'(err_pattern), 32'h0);
    clear_err = 1'b1;
    steps(1);
    clear_err = 1'b0;
    check("collide_error_wins", 32'(err_pattern), 32'h1);
    steps(HOLD);

    // Two anodes low: err_anode is set, and no frame is produced.
    fd_cnt  = 0;
    anode   = 4'b1100;
    cathode = P0;
    steps(HOLD);
    anode   = 4'b1111;
    steps(HOLD);
    check("multi_anode_err", 32'(err_anode), 32'h1);
    check("multi_anode_no_frame", fd_cnt, 0);

    // Glitches shorter than SETTLE never sample. Slots 1..3 are scanned first,
    // so a stray slot-0 sample would complete the frame.
    do_reset();
    scan({P3, P2, P1, P0}, 4'b1110);
    check("partial_no_frame", fd_cnt, 0);
    fd_cnt = 0;
    anode  = 4'b1110;
    for (int k = 0; k < 10; k++) begin
      cathode = k[0] ? P6 : P5;
      steps(8);
    end
    anode   = 4'b1111;
    cathode = PBL;
    steps(HOLD);
    check("glitch_no_frame", fd_cnt, 0);
    scan({P3, P2, P1, P9}, 4'b0001);
    check("glitch_then_slot0_done", fd_cnt, 1);
    check("glitch_then_slot0_frame", 32'(frame), 32'h3219);

    // Reset in the middle of a frame.
    scan({P0, P0, P4, P5}, 4'b0011);
    RESET_N = 1'b0;
    #1;
    check("midrst_frame", 32'(frame), 32'h0);
    check("midrst_blank", 32'(blank), 32'h0);
    check("midrst_outputs", {28'h0, frame_done, err_pattern, err_anode, stall}, 32'h0);
    steps(2);
    RESET_N = 1'b1;
    steps(1);
    scan({P7, P6, P0, P0}, 4'b1100);
    check("midrst_upper_no_frame", fd_cnt, 0);
    scan({P7, P6, P4, P5}, 4'b0011);
    check("midrst_rescan_done", fd_cnt, 1);
    check("midrst_rescan_frame", 32'(frame), 32'h7645);

    // Stall: an idle bus does not reset the timeout. A valid sample clears it.
    do_reset();
    steps(20);
    check("stall_early", 32'(stall), 32'h0);
    steps(60);
    check("stall_set", 32'(stall), 32'h1);
    anode   = 4'b1110;
    cathode = P4;
    steps(25);
    check("stall_cleared", 32'(stall), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
